// File: rtl/act_backward_if.sv
// act_backward_if: gradient-in / gradient-out stream bundle for the activation backward unit.
interface act_backward_if #(
    parameter int WIDTH = 8
);
    logic [1:0]              mode;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] grad;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] gradOut;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output mode, x, grad, in_valid, out_ready,
        input  in_ready, gradOut, out_valid
    );

    modport slave (
        input  mode, x, grad, in_valid, out_ready,
        output in_ready, gradOut, out_valid
    );
endinterface

// File: rtl/act_backward.sv
// act_backward: backward pass for relu/leaky/hardtanh (one-cycle gate) and sigmoid (two serial multiplies).
module act_backward #(
    parameter int WIDTH                = 8,
    parameter int DECIMAL_POINT        = 4,
    parameter int NEGATIVE_SLOPE_SHIFT = 5
) (
    input logic           iClk,
    input logic           iRst,
    act_backward_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1 <<< DECIMAL_POINT);
    localparam logic signed [WIDTH-1:0] ZERO    = '0;
    localparam logic signed [W2-1:0]    ONE_W   = W2'(1 <<< DECIMAL_POINT);
    localparam logic signed [W2-1:0]    SAT_MAX = W2'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [W2-1:0]    SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

    state_t                  r_state, w_next;
    logic [CW-1:0]           r_cnt;
    logic signed [W2-1:0]    r_a, r_acc, w_pp, w_sum, w_x_ext;
    logic [WIDTH-1:0]        r_b;
    logic signed [WIDTH-1:0] r_grad, r_grad_out, w_simple, w_leaky, w_gate, w_d;
    logic                    w_accept, w_last, w_d_step;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [W2-1:0] v);
        return v > SAT_MAX ? SAT_MAX[WIDTH-1:0] : (v < SAT_MIN ? SAT_MIN[WIDTH-1:0] : v[WIDTH-1:0]);
    endfunction

    assign bus.in_ready  = iRst && (r_state == IDLE || (r_state == DONE && bus.out_ready));
    assign bus.out_valid = r_state == DONE;
    assign bus.gradOut   = r_grad_out;
    assign w_accept      = bus.in_valid && bus.in_ready;

    // Simple modes; signed-only operands keep the >>> arithmetic.
    assign w_leaky  = bus.grad >>> NEGATIVE_SLOPE_SHIFT;
    assign w_gate   = (bus.x >= -ONE && bus.x <= ONE) ? bus.grad : ZERO;
    assign w_simple = bus.mode == 2'd2 ? w_gate :
                      !bus.x[WIDTH-1] ? bus.grad :
                      bus.mode == 2'd1 ? w_leaky : ZERO;

    // Serial signed multiply over the multiplier bits; the MSB weighs negative.
    assign w_x_ext  = {{WIDTH{bus.x[WIDTH-1]}}, bus.x};
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_d_step = r_state == MUL1 && r_cnt == CW'(WIDTH);
    assign w_pp     = r_b[0] ? (w_last ? -r_a : r_a) : '0;
    assign w_sum    = r_acc + w_pp;
    assign w_d      = sat(r_acc >>> DECIMAL_POINT);

    always_ff @(posedge iClk) begin
        r_state <= !iRst ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = bus.mode == 2'd3 ? MUL1 : DONE;
        else if (r_state == DONE)
            w_next = bus.out_ready ? IDLE : DONE;
        else if (r_state == MUL1)
            w_next = w_d_step ? MUL2 : MUL1;
        else if (r_state == MUL2)
            w_next = w_last ? DONE : MUL2;
    end

    // (One - s) is the multiplicand so it never needs more than the 2*WIDTH accumulator width.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_grad_out <= '0;
            r_acc      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_grad     <= '0;
        end else if (w_accept) begin
            if (bus.mode == 2'd3) begin
                r_a    <= ONE_W - w_x_ext;
                r_b    <= bus.x;
                r_grad <= bus.grad;
                r_acc  <= '0;
                r_cnt  <= '0;
            end else begin
                r_grad_out <= w_simple;
            end
        end else if (w_d_step) begin
            r_a   <= {{WIDTH{w_d[WIDTH-1]}}, w_d};
            r_b   <= r_grad;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == MUL1 || r_state == MUL2) begin
            r_acc <= w_sum;
            r_a   <= r_a <<< 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
            if (r_state == MUL2 && w_last)
                r_grad_out <= sat(w_sum >>> DECIMAL_POINT);
        end
    end
endmodule

// File: tb/tb_act_backward.sv
// tb_act_backward: directed vectors with a queue scoreboard checked by an independent output monitor.
module tb_act_backward;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   waits;
    int   n;
    logic signed [7:0] exp_q[$];
    logic signed [7:0] mon_exp;

    act_backward_if #(.WIDTH(8)) bus ();

    act_backward #(
        .WIDTH(8),
        .DECIMAL_POINT(4),
        .NEGATIVE_SLOPE_SHIFT(5)
    ) dut (
        .iClk(clk),
        .iRst(rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // Drive one item and hold it until accepted; called at a falling edge.
    task automatic send(input logic [1:0] m, input int xv, input int gv, input int ev, input bit chk);
        bus.mode     = m;
        bus.x        = 8'(xv);
        bus.grad     = 8'(gv);
        bus.in_valid = 1'b1;
        if (chk) exp_q.push_back(8'(ev));
        waits = 0;
        #1;
        while (!bus.in_ready && waits < 100) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout got=in_ready_low want=accept");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        #1;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output got=%0d want=none", bus.gradOut);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.gradOut !== mon_exp) begin
                    n_bad++;
                    $display("FAIL gradOut got=%0d want=%0d", bus.gradOut, mon_exp);
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.mode      = 2'd0;
        bus.x         = '0;
        bus.grad      = '0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_gradOut", bus.gradOut, 0);
        check("reset_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", bus.in_ready, 1);
        @(negedge clk);

        send(2'd0, -3, 20, 0, 1'b1);
        check("relu_latency_edges", bus.out_valid, 1);
        send(2'd0, 0, -7, -7, 1'b1);
        check("relu_b2b_wait", waits, 0);
        send(2'd0, 5, 9, 9, 1'b1);
        check("relu_b2b_wait2", waits, 0);

        send(2'd1, -1, -64, -2, 1'b1);
        send(2'd1, -1, 31, 0, 1'b1);
        send(2'd1, 5, -64, -64, 1'b1);
        send(2'd2, 16, 5, 5, 1'b1);
        send(2'd2, 17, 5, 0, 1'b1);
        send(2'd2, -16, 5, 5, 1'b1);
        send(2'd2, -17, 5, 0, 1'b1);
        drain();

        send(2'd3, 8, 32, 8, 1'b1);
        check("sigmoid_busy_in_ready", bus.in_ready, 0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sigmoid_latency_edges", n, 17);
        send(2'd3, 16, 32, 0, 1'b1);
        send(2'd3, -64, 16, -128, 1'b1);
        drain();

        bus.out_ready = 1'b0;
        send(2'd0, 1, 9, 9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_gradOut", bus.gradOut, 9);
            check("bp_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        send(2'd0, 2, -3, -3, 1'b1);
        check("bp_handoff_wait", waits, 0);
        check("bp_new_gradOut", bus.gradOut, -3);
        drain();

        send(2'd3, -64, 16, -128, 1'b1);
        drain();
        send(2'd3, 8, 32, 8, 1'b0);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_gradOut", bus.gradOut, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("midrst_release_in_ready", bus.in_ready, 1);
        repeat (20) @(negedge clk);
        check("midrst_no_stale", bus.out_valid, 0);
        send(2'd0, 4, 11, 11, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/act_backward.md
# act_backward

Streaming backward-pass (gradient) unit for the activation library. It takes an upstream gradient plus the saved forward operand and returns the input gradient. For ReLU, leaky ReLU and hardtanh it applies a one-cycle gate or scale. For sigmoid it computes grad·s·(1−s) using one serial shift-add multiplier, used twice. It sits between the training loss/gradient stream and the weight-update path, mirroring the forward activation units using the same signed fixed-point format.

## Interface
- WIDTH, 8, total bits (1 sign + WIDTH-1 data), two's complement
- DECIMAL_POINT, 4, fraction bits; One = 1 <<< DECIMAL_POINT
- NEGATIVE_SLOPE_SHIFT, 5, leaky slope = 2^-SHIFT
- iClk  in  1  clock, rising edge
- iRst  in  1  reset, synchronous, active-low
- mode  in  2  00 relu, 01 leaky relu, 10 hardtanh, 11 sigmoid; sampled at accept
- x  in  WIDTH  signed; forward pre-activation (modes 00/01/10) or forward sigmoid output s (mode 11)
- grad  in  WIDTH  signed upstream gradient
- in_valid  in  1  x/grad/mode valid
- in_ready  out  1  unit can accept this cycle
- gradOut  out  WIDTH  signed input gradient
- out_valid  out  1  gradOut valid
- out_ready  in  1  consumer takes gradOut

## Operation
- States: IDLE, MUL1, MUL2, DONE.
- Accept when in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- out_valid = (state==DONE).
- On accept in modes 00/01/10, result is registered on the accept edge and the next state is DONE:
  - relu: x >= 0 → grad, else 0 (x==0 passes grad).
  - leaky: x >= 0 → grad, else grad >>> NEGATIVE_SLOPE_SHIFT (arithmetic, floor).
  - hardtanh: −One <= x <= One (inclusive) → grad, else 0.
- On accept in mode 11, latch s=x and grad, then go to MUL1:
  - MUL1: WIDTH cycles of serial signed multiply p1 = s·(One−s), 2·WIDTH-bit product; then d = sat(p1 >>> DECIMAL_POINT).
  - MUL2: WIDTH cycles computing p2 = grad·d; then gradOut = sat(p2 >>> DECIMAL_POINT); go to DONE.
- sat(): clamp to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
- Shifts use floor rounding (arithmetic shift right). No other rounding.
- DONE & out_ready & !in_valid → IDLE.
- DONE & out_ready & in_valid → accept the new item (same rules as IDLE).
- DONE & !out_ready → hold. gradOut is stable and in_ready=0.
- Inputs are ignored while in MUL1/MUL2. in_ready=0 there.

## Timing
- Reset (iRst low at a rising edge): state=IDLE, gradOut=0, out_valid=0, multiplier accumulators cleared.
- in_ready=0 while iRst is low. It is 1 in the first cycle after release.
- Reset mid-MUL1/MUL2/DONE aborts the operation. The pending result is never presented.
- Latency, modes 00/01/10: accept edge k → out_valid high in the cycle after edge k (1 cycle).
  - Throughput is 1 item/cycle when out_ready is held high.
- Latency, mode 11: accept edge k → out_valid high after edge k + 2·WIDTH + 1 (17 cycles at WIDTH=8).
  - Throughput is 1 item per 2·WIDTH+2 cycles.
- gradOut changes only on an accept edge (simple modes) or on the MUL2→DONE edge.
- A mode change between items takes effect at the next accept. No flush is needed.

## Test plan
- Relu, WIDTH=8, DECIMAL_POINT=4:
  - x=−3, grad=20 → gradOut=0.
  - x=0, grad=−7 → −7.
  - Each appears 1 cycle after accept. Stream back-to-back with out_ready=1 → one result per cycle.
- Leaky, SHIFT=5:
  - x=−1, grad=−64 → −2.
  - x=−1, grad=31 → 0.
  - x=5, grad=−64 → −64.
- Hardtanh:
  - x=16, grad=5 → 5.
  - x=17 → 0.
  - x=−16 → 5.
  - x=−17 → 0.
- Sigmoid:
  - s=8, grad=32 → d=4, gradOut=8, out_valid exactly 17 cycles after accept.
  - s=16 → 0.
  - s=−64, grad=16 → d saturates to −128, gradOut=−128.
- Backpressure: out_ready=0 for 5 cycles in DONE → gradOut/out_valid stable, in_ready=0. Then raise out_ready with in_valid=1 → handoff and new accept on the same edge.
- Reset during MUL2 (iRst=0 for one edge) → next cycle out_valid=0, gradOut=0. After release in_ready=1, and a new relu item returns its correct result with no stale sigmoid output.
